// File: rtl/tone_gen_prog_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tone_pkg : note half-period table and FSM state encoding for tone_gen_prog
// Rev 1.0
// ---------------------------------------------------------------------------
package tone_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PLAY    = 2'd1;
    localparam logic [1:0] ST_SUSTAIN = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    // Half-period in sys_clk cycles for each note, index = key code - 1
    function automatic logic [31:0] tone_half(input logic [3:0] idx);
        logic [31:0] h;
        case (idx)
            4'd0:    h = 32'd190_839;
            4'd1:    h = 32'd170_068;
            4'd2:    h = 32'd151_515;
            4'd3:    h = 32'd143_266;
            4'd4:    h = 32'd127_551;
            4'd5:    h = 32'd113_636;
            4'd6:    h = 32'd101_214;
            4'd7:    h = 32'd95_602;
            4'd8:    h = 32'd85_179;
            4'd9:    h = 32'd75_872;
            4'd10:   h = 32'd71_633;
            default: h = 32'd63_775;
        endcase
        return h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_gen_prog_half_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// half_cnt : loadable half-period counter with toggle output and boundary strobe
// Rev 1.0
// ---------------------------------------------------------------------------
module half_cnt #(
    parameter int CNT_W = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             restart,
    input  logic             stop,
    input  logic [CNT_W-1:0] half,
    output logic             tone,
    output logic             boundary
);

    logic [CNT_W-1:0] cnt;

    assign boundary = en && (cnt == half - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tone <= 1'b0;
        end else if (stop) begin
            cnt  <= '0;
            tone <= 1'b0;
        end else if (restart) begin
            cnt  <= '0;
        end else if (boundary) begin
            cnt  <= '0;
            tone <= ~tone;
        end else if (en) begin
            cnt  <= cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/tone_gen_prog.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tone_gen_prog : key-selected square-wave tone with octave shift, glitch-free
//                 note changes and programmable release sustain
// Rev 1.0
// ---------------------------------------------------------------------------
module tone_gen_prog
    import tone_pkg::*;
#(
    parameter int N_TONES     = 12,
    parameter int CNT_W       = 18,
    parameter int OCT_W       = 2,
    parameter int SUSTAIN_CYC = 0,
    parameter int SUS_W       = 32,
    parameter int HALF_SHIFT  = 0
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [3:0]       key_pad,
    input  logic [OCT_W-1:0] octave,
    output logic             tone_clk,
    output logic             playing,
    output logic [3:0]       cur_tone
);

    function automatic logic [CNT_W-1:0] half_of(input logic [3:0] key,
                                                 input logic [OCT_W-1:0] oct);
        logic [31:0] h;
        h = (tone_half(key - 4'd1) >> HALF_SHIFT) >> oct;
        return h[CNT_W-1:0];
    endfunction

    logic [1:0]       state;
    logic [CNT_W-1:0] half_r;
    logic [OCT_W-1:0] octave_r;
    logic             pend_valid;
    logic [3:0]       pend_key;
    logic [OCT_W-1:0] pend_oct;
    logic [SUS_W-1:0] sus_cnt;

    logic             valid;
    logic             boundary;
    logic             fall;
    logic             apply;
    logic [3:0]       eff_key;
    logic [OCT_W-1:0] eff_oct;
    logic             differs;
    logic             cnt_en;
    logic             cnt_restart;
    logic             cnt_stop;

    assign valid   = (key_pad != 4'd0) && (key_pad <= 4'(N_TONES));
    assign fall    = boundary && tone_clk;
    assign apply   = fall && pend_valid && valid &&
                     ((state == ST_PLAY) || (state == ST_SUSTAIN));
    // Compare against the tone that will be sounding after this edge
    assign eff_key = apply ? pend_key : cur_tone;
    assign eff_oct = apply ? pend_oct : octave_r;
    assign differs = (key_pad != eff_key) || (octave != eff_oct);

    assign cnt_en      = (state != ST_IDLE);
    assign cnt_restart = (state == ST_IDLE) && valid;
    assign cnt_stop    = (state == ST_DRAIN) && (!tone_clk || fall);
    assign playing     = (state != ST_IDLE);

    half_cnt #(
        .CNT_W (CNT_W)
    ) u_half_cnt (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .en       (cnt_en),
        .restart  (cnt_restart),
        .stop     (cnt_stop),
        .half     (half_r),
        .tone     (tone_clk),
        .boundary (boundary)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            half_r     <= '0;
            cur_tone   <= 4'd0;
            octave_r   <= '0;
            pend_valid <= 1'b0;
            pend_key   <= 4'd0;
            pend_oct   <= '0;
            sus_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (valid) begin
                        state      <= ST_PLAY;
                        half_r     <= half_of(key_pad, octave);
                        cur_tone   <= key_pad;
                        octave_r   <= octave;
                        pend_valid <= 1'b0;
                    end
                end
                ST_PLAY, ST_SUSTAIN: begin
                    if (valid) begin
                        state <= ST_PLAY;
                        if (apply) begin
                            half_r   <= half_of(pend_key, pend_oct);
                            cur_tone <= pend_key;
                            octave_r <= pend_oct;
                        end
                        pend_valid <= differs;
                        if (differs) begin
                            pend_key <= key_pad;
                            pend_oct <= octave;
                        end
                    end else if (state == ST_PLAY) begin
                        state      <= (SUSTAIN_CYC > 0) ? ST_SUSTAIN : ST_DRAIN;
                        sus_cnt    <= '0;
                        pend_valid <= 1'b0;
                    end else if (sus_cnt == SUS_W'(SUSTAIN_CYC - 1)) begin
                        state <= ST_DRAIN;
                    end else begin
                        sus_cnt <= sus_cnt + SUS_W'(1);
                    end
                end
                default: begin
                    if (!tone_clk || fall) begin
                        state    <= ST_IDLE;
                        cur_tone <= 4'd0;
                    end
                end
            endcase
        end
    end

    // A half-period below 2 cannot produce a clean square wave
    always_ff @(posedge sys_clk) begin
        if (sys_rst_n && valid) begin
            assert (half_of(key_pad, octave) >= CNT_W'(2))
            else $error("tone_gen_prog: half-period below 2 for key %0d octave %0d",
                        key_pad, octave);
        end
    end

endmodule
`default_nettype wire
